// File: rtl/frame_key_scheduler_if.sv
// frame_key_scheduler_if: host seed valid/ready handshake into the key scheduler
interface frame_key_scheduler_if #(
    parameter int KEY_W = 12
);
    logic [KEY_W-1:0] seed_in;
    logic             seed_valid;
    logic             seed_ready;
    logic             seed_rejected;

    modport master (output seed_in, seed_valid, input seed_ready, seed_rejected);
    modport slave  (input seed_in, seed_valid, output seed_ready, seed_rejected);
endinterface

// File: rtl/frame_key_scheduler.sv
// frame_key_scheduler: per-frame LFSR reseed control with host seed holding register and frame timing checks
module frame_key_scheduler #(
    parameter int               KEY_W           = 12,
    parameter logic [KEY_W-1:0] DEFAULT_SEED    = 12'hACE,
    parameter int               LINES_PER_FRAME = 480,
    parameter int               LINE_W          = 10,
    parameter int               EPOCH_W         = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       i_vsync,
    input  logic                       i_href,
    frame_key_scheduler_if.slave       seed_bus,
    output logic                       lfsr_load,
    output logic [KEY_W-1:0]           lfsr_seed,
    output logic [EPOCH_W-1:0]         key_epoch,
    output logic [LINE_W-1:0]          line_count,
    output logic                       locked,
    output logic                       frame_err,
    output logic                       sync_err
);
    typedef enum logic [1:0] {IDLE, SYNC, LOAD, ACTIVE} state_t;

    state_t           state, state_nx;
    logic             vs_q, href_q, pend_full;
    logic [KEY_W-1:0] pend_seed;
    logic             vs_fall, href_rise, boundary, xfer, watching;

    assign vs_fall   = vs_q & ~i_vsync;
    assign href_rise = ~href_q & i_href;
    assign watching  = (state == SYNC) || (state == ACTIVE);
    assign boundary  = enable & vs_fall & watching;
    assign xfer      = seed_bus.seed_valid & ~pend_full;
    assign seed_bus.seed_ready = ~pend_full;

    // next state: disable wins, then a frame boundary, then the fixed IDLE->SYNC and LOAD->ACTIVE steps
    always_comb
        state_nx = !enable ? IDLE : boundary ? LOAD : (state == IDLE) ? SYNC : (state == LOAD) ? ACTIVE : state;

    // registered copies of the sync inputs for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            vs_q   <= 1'b0;
            href_q <= 1'b0;
        end else begin
            vs_q   <= i_vsync;
            href_q <= i_href;
        end
    end

    // FSM with registered reseed pulse, lock flag and frame timing checks
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            lfsr_load  <= 1'b0;
            locked     <= 1'b0;
            line_count <= '0;
            frame_err  <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            lfsr_load <= state_nx == LOAD;
            locked    <= state_nx == ACTIVE;
            frame_err <= boundary && state == ACTIVE && line_count != LINE_W'(LINES_PER_FRAME);
            if (boundary)
                line_count <= '0;
            else if (enable && state == ACTIVE && href_rise && line_count != '1)
                line_count <= line_count + 1'b1;
            sync_err <= enable & (sync_err | (watching & i_href & i_vsync));
        end
    end

    // one-entry seed holding register; a held seed is committed only when entering LOAD
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_full              <= 1'b0;
            pend_seed              <= '0;
            lfsr_seed              <= DEFAULT_SEED;
            key_epoch              <= '0;
            seed_bus.seed_rejected <= 1'b0;
        end else begin
            seed_bus.seed_rejected <= xfer & (seed_bus.seed_in == '0);
            if (boundary && pend_full) begin
                lfsr_seed <= pend_seed;
                key_epoch <= key_epoch + 1'b1;
                pend_full <= 1'b0;
            end else if (xfer && seed_bus.seed_in != '0) begin
                pend_seed <= seed_bus.seed_in;
                pend_full <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_frame_key_scheduler.sv
// tb_frame_key_scheduler: randomized frame/seed stimulus against a behavioural key-schedule model
module tb_frame_key_scheduler;
    localparam int KEY_W = 12;
    localparam int LPF   = 480;

    logic             clk = 0, reset = 0, enable = 0, i_vsync = 0, i_href = 0;
    logic             lfsr_load, locked, frame_err, sync_err;
    logic [KEY_W-1:0] lfsr_seed;
    logic [7:0]       key_epoch;
    logic [9:0]       line_count;

    frame_key_scheduler_if #(.KEY_W(KEY_W)) sif ();

    frame_key_scheduler dut (
        .clk(clk), .reset(reset), .enable(enable), .i_vsync(i_vsync), .i_href(i_href),
        .seed_bus(sif.slave), .lfsr_load(lfsr_load), .lfsr_seed(lfsr_seed), .key_epoch(key_epoch),
        .line_count(line_count), .locked(locked), .frame_err(frame_err), .sync_err(sync_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // model: run = out of IDLE, framed = has seen a boundary since enable, in_load = reseed cycle
    bit               m_run, m_framed, m_load, m_lock, m_ferr, m_serr, m_rej, m_acc, pvs, phref;
    int               m_lines;
    logic [KEY_W-1:0] m_seed;
    logic [7:0]       m_epoch;
    logic [KEY_W-1:0] q[$];
    int               offer_pct;
    bit               req_on;
    logic [KEY_W-1:0] req_seed;

    task automatic model_reset();
        {m_run, m_framed, m_load, m_lock, m_ferr, m_serr, m_rej, m_acc, pvs, phref} = '0;
        m_lines = 0; m_seed = 12'hACE; m_epoch = 0; q.delete();
    endtask

    task automatic check_all();
        check("lfsr_load", lfsr_load, m_load);
        check("lfsr_seed", lfsr_seed, m_seed);
        check("key_epoch", key_epoch, m_epoch);
        check("line_count", line_count, m_lines);
        check("locked", locked, m_lock);
        check("frame_err", frame_err, m_ferr);
        check("sync_err", sync_err, m_serr);
        check("seed_ready", sif.seed_ready, q.size() == 0);
        check("seed_rejected", sif.seed_rejected, m_rej);
    endtask

    task automatic cycle(input bit en, input bit vs, input bit href);
        bit fall, rise, bnd, acc, active;
        @(negedge clk);
        check_all();
        if (m_acc) sif.seed_valid = 0;
        if (!sif.seed_valid && req_on) begin
            sif.seed_valid = 1; sif.seed_in = req_seed; req_on = 0;
        end else if (!sif.seed_valid && $urandom_range(99) < offer_pct) begin
            sif.seed_valid = 1;
            sif.seed_in = ($urandom_range(7) == 0) ? 12'h000 : 12'($urandom_range(4095, 1));
        end
        enable = en; i_vsync = vs; i_href = href;
        fall   = pvs & ~vs;
        rise   = ~phref & href;
        active = m_framed & ~m_load;
        bnd    = en & m_run & ~m_load & fall;
        acc    = sif.seed_valid & (q.size() == 0);
        m_ferr = bnd & active & (m_lines != LPF);
        m_serr = en & (m_serr | (m_run & ~m_load & href & vs));
        if (en) begin
            if (bnd) m_lines = 0;
            else if (active && rise && m_lines < 1023) m_lines++;
        end
        if (bnd && q.size() != 0) begin
            m_seed = q.pop_front();
            m_epoch++;
        end
        m_rej = acc && sif.seed_in == 0;
        if (acc && sif.seed_in != 0) q.push_back(sif.seed_in);
        m_acc    = acc;
        m_lock   = en & m_framed & ~bnd;
        m_framed = en & (m_framed | bnd);
        m_load   = bnd;
        m_run    = en;
        pvs      = vs;
        phref    = href;
    endtask

    task automatic lines(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(2, 1)) cycle(1, 0, 1);
            repeat ($urandom_range(2, 1)) cycle(1, 0, 0);
        end
    endtask

    task automatic frame(input int n, input bit inj, input bit fall_req, input logic [KEY_W-1:0] fs);
        int vlen = $urandom_range(6, 3);
        for (int i = 0; i < vlen; i++) cycle(1, 1, inj && i == 1);
        if (fall_req) begin req_on = 1; req_seed = fs; end
        lines(n);
    endtask

    initial begin
        sif.seed_valid = 0; sif.seed_in = 0; req_on = 0; offer_pct = 0;
        model_reset();
        repeat (3) cycle(0, 0, 0);
        reset = 1;
        cycle(1, 0, 0);
        lines(3);
        frame(3, 0, 0, 0);
        req_on = 1; req_seed = 12'h5A3;
        frame(480, 0, 0, 0);
        req_on = 1; req_seed = 12'h000;
        frame(480, 0, 0, 0);
        frame(479, 0, 1, 12'h0F0);
        frame(480, 0, 0, 0);
        frame(480, 0, 0, 0);
        frame(480, 1, 0, 0);
        frame(20, 0, 0, 0);
        repeat (5) cycle(0, 0, 0);
        offer_pct = 20;
        lines(2);
        for (int f = 0; f < 6; f++)
            frame((f == 2) ? 1030 : $urandom_range(LPF + 1, LPF - 1), $urandom_range(3) == 0, 0, 0);
        lines(20);
        @(posedge clk);
        #2 reset = 0;
        #1;
        check("rst_lfsr_load", lfsr_load, 0);
        check("rst_lfsr_seed", lfsr_seed, 12'hACE);
        check("rst_key_epoch", key_epoch, 0);
        check("rst_line_count", line_count, 0);
        check("rst_locked", locked, 0);
        check("rst_seed_ready", sif.seed_ready, 1);
        sif.seed_valid = 0; req_on = 0; offer_pct = 0;
        model_reset();
        repeat (3) cycle(0, 0, 0);
        reset = 1;
        lines(4);
        offer_pct = 20;
        frame(480, 0, 0, 0);
        frame(478, 0, 0, 0);
        frame(480, 0, 0, 0);
        cycle(1, 1, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/frame_key_scheduler.md
Name: frame_key_scheduler

Overview:
- Controls the per-frame LFSR scramble key in the pclk domain of the camera-link slave path.
- At each frame boundary (vsync falling edge), issues a one-cycle reseed pulse together with the active seed to the LFSR code generator.
- Accepts new seeds from the host through a one-entry valid/ready holding register. A new seed takes effect only at a frame boundary.
- Checks frame timing: lines per frame, and href asserted during vsync.

Parameters:
KEY_W, 12, width of seed and LFSR key
DEFAULT_SEED, 12'hACE, seed loaded at reset; must be nonzero
LINES_PER_FRAME, 480, expected href pulses per frame
LINE_W, 10, line counter width
EPOCH_W, 8, key epoch counter width

Ports:
clk  in  1  pixel clock (pclk domain); all logic on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
enable  in  1  run control; 0 forces IDLE
i_vsync  in  1  frame sync, synchronous to clk, high during vertical blanking
i_href  in  1  line valid, synchronous to clk
seed_in  in  KEY_W  host seed
seed_valid  in  1  seed_in valid
seed_ready  out  1  holding register empty
seed_rejected  out  1  one-cycle pulse: a zero seed was offered and dropped
lfsr_load  out  1  one-cycle reseed pulse to the LFSR
lfsr_seed  out  KEY_W  seed to load; stable whenever lfsr_load=1
key_epoch  out  EPOCH_W  count of committed host seeds; wraps
line_count  out  LINE_W  href rising edges seen in the current frame
locked  out  1  state is ACTIVE
frame_err  out  1  one-cycle pulse: frame ended with line_count != LINES_PER_FRAME
sync_err  out  1  sticky: href seen while vsync high

Behaviour:
- Reset values:
  - Outputs: lfsr_load=0, lfsr_seed=DEFAULT_SEED, seed_ready=1, seed_rejected=0, key_epoch=0, line_count=0, locked=0, frame_err=0, sync_err=0.
  - Internal: state=IDLE, vs_q=0, href_q=0, pending empty.
- Edge detect:
  - vs_q and href_q are registered copies of i_vsync and i_href.
  - vs_fall = vs_q & ~i_vsync.
  - href_rise = ~href_q & i_href.
- FSM states IDLE, SYNC, LOAD, ACTIVE:
  - IDLE: if enable=1, go to SYNC.
  - SYNC: if vs_fall, go to LOAD. Never reseed mid-frame on entry.
  - LOAD: lfsr_load=1 for exactly this cycle (Moore output), then go to ACTIVE. The pulse is therefore in the cycle after vs_fall is detected.
  - ACTIVE: if vs_fall, go to LOAD. Every frame reseeds, so master and slave realign each frame.
  - From any state, enable=0 goes to IDLE on the next edge. No lfsr_load is issued. line_count and pending seed are kept; sync_err is cleared.
- Seed commit:
  - On the transition into LOAD, if pending is full: lfsr_seed <= pending seed, pending is emptied, and key_epoch increments (wraps at 2^EPOCH_W).
  - Otherwise lfsr_seed is unchanged.
- Host handshake:
  - seed_ready = ~pending_full.
  - A transfer occurs when seed_valid & seed_ready.
  - A nonzero seed is stored and sets pending_full.
  - seed_in==0 is consumed and not stored (an all-zero LFSR locks up); seed_rejected pulses for 1 cycle.
  - A transfer in the same cycle as vs_fall is not committed at that boundary; it is committed at the next one.
  - While pending is full, seed_ready=0 and the host must hold its seed.
- Line count:
  - In ACTIVE, increments on href_rise and saturates at all-ones.
  - Cleared on the transition into LOAD.
- frame_err:
  - Evaluated on ACTIVE→LOAD only, using line_count before it is cleared.
  - The SYNC→LOAD transition (first frame after enable) never flags.
- sync_err:
  - Set in SYNC/ACTIVE when i_href=1 and i_vsync=1 on the same cycle.
  - Held until enable=0 or reset.
- Reset asserted mid-frame: all state returns to reset values immediately (asynchronous). After release, the block needs enable and a new vsync fall before the next lfsr_load.

Test Plan:
- Reset, enable=1, mid-frame vsync low, 3 lines, then vsync 1→0 → no lfsr_load before the vsync fall; single-cycle lfsr_load one cycle after the fall, lfsr_seed=12'hACE, key_epoch=0, locked=1 after.
- Host offers seed 12'h5A3 mid-frame → seed_ready drops to 0; at next vsync fall lfsr_load with lfsr_seed=12'h5A3, key_epoch=1, seed_ready=1 again.
- Host offers seed 0 → seed_rejected pulses 1 cycle, seed_ready stays 1, next reload keeps the previous seed, key_epoch unchanged.
- Seed 12'h0F0 accepted on the same cycle as a vsync fall → that reload uses the old seed; the following frame reload uses 12'h0F0, key_epoch +1.
- Frame with 479 href pulses, then one with 480 → frame_err pulses once at the first boundary, not at the second; line_count reads 0 after each LOAD.
- href high while vsync high → sync_err=1 and held; enable=0 → IDLE, sync_err=0, locked=0, no lfsr_load while disabled.
